// File: rtl/kws_cmvn_pkg.sv
// Shared definitions for the KWS cepstral mean/variance normaliser:
// default geometry, table-select encodings and the identity inverse-std value.
package kws_cmvn_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_FRAC_W   = 24;
    localparam int DEF_NUM_FEAT = 20;

    // cfg_sel encodings
    localparam logic CFG_SEL_MEAN = 1'b0;
    localparam logic CFG_SEL_ISTD = 1'b1;

    // 1.0 in the default fixed-point format (istd value of an identity table)
    localparam logic [DEF_DATA_W-1:0] ISTD_IDENTITY = DEF_DATA_W'(1) << DEF_FRAC_W;

endpackage

// File: rtl/cmvn_param_tbl.sv
// Per-feature mean / inverse-std tables for cmvn_stream.
// Both tables live in register arrays that reset to identity (mean 0,
// istd 1.0). Writes are accepted only while the datapath is idle and the
// address is inside the table; rejected writes raise a one-cycle cfg_err.
// A single registered read port returns both entries for one address.
module cmvn_param_tbl
    import kws_cmvn_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int NUM_FEAT = DEF_NUM_FEAT,
    parameter int IDX_W    = $clog2(NUM_FEAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              busy,
    input  logic              in_valid,
    output logic              cfg_err,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_mean,
    output logic [DATA_W-1:0] rd_istd
);

    localparam logic [DATA_W-1:0] ISTD_ONE = DATA_W'(1) << FRAC_W;
    localparam logic [IDX_W:0]    DEPTH    = (IDX_W+1)'(NUM_FEAT);

    logic [DATA_W-1:0] mean_r [NUM_FEAT];
    logic [DATA_W-1:0] istd_r [NUM_FEAT];
    logic [DATA_W-1:0] rd_mean_r;
    logic [DATA_W-1:0] rd_istd_r;
    logic              cfg_err_r;
    logic              addr_ok_s;
    logic              idle_s;
    logic              wr_ok_s;

    // Decide whether the current write request may touch the tables
    always_comb begin
        addr_ok_s = ({1'b0, cfg_addr} < DEPTH);
        idle_s    = !busy && !in_valid;
        wr_ok_s   = cfg_we && addr_ok_s && idle_s;
    end

    // Table storage: identity on reset, gated single-entry write otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                mean_r[i] <= {DATA_W{1'b0}};
                istd_r[i] <= ISTD_ONE;
            end
        end else if (wr_ok_s) begin
            if (cfg_sel == CFG_SEL_ISTD) begin
                istd_r[cfg_addr] <= cfg_wdata;
            end else begin
                mean_r[cfg_addr] <= cfg_wdata;
            end
        end
    end

    // Registered read port, updated whenever the pipeline advances
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mean_r <= {DATA_W{1'b0}};
            rd_istd_r <= ISTD_ONE;
        end else if (rd_en) begin
            rd_mean_r <= mean_r[rd_addr];
            rd_istd_r <= istd_r[rd_addr];
        end
    end

    // One-cycle error pulse for every rejected write request
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we && !wr_ok_s;
        end
    end

    assign rd_mean = rd_mean_r;
    assign rd_istd = rd_istd_r;
    assign cfg_err = cfg_err_r;

endmodule

// File: rtl/cmvn_stream.sv
// Streaming cepstral mean/variance normaliser: out = (x - mean[k]) * istd[k]
// in signed fixed point, k being the feature position within the frame.
// Three-stage stallable pipeline:
//   S1  sample, index and registered table entries
//   S2  product (x - mean) * istd at full precision
//   S3  floor-shifted, width-reduced result (output register)
// The whole pipeline moves only when the output register can take new data.
// Build option CMVN_SAT_EN: clamp out-of-range results and add port out_sat;
// without it the result is plainly truncated.
module cmvn_stream
    import kws_cmvn_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int NUM_FEAT = DEF_NUM_FEAT,
    parameter int IDX_W    = $clog2(NUM_FEAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              frame_done,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_err,
    output logic              busy
`ifdef CMVN_SAT_EN
    ,
    output logic              out_sat
`endif
);

    localparam int              PW       = 2*DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    logic                     adv_s;
    logic                     accept_s;
    logic                     busy_s;
    logic [IDX_W-1:0]         idx_r;

    logic                     s1_valid_r;
    logic [DATA_W-1:0]        s1_data_r;
    logic [IDX_W-1:0]         s1_idx_r;
    logic [DATA_W-1:0]        tbl_mean_s;
    logic [DATA_W-1:0]        tbl_istd_s;
    logic signed [DATA_W:0]   diff_s;
    logic signed [PW-1:0]     prod_s;

    logic                     s2_valid_r;
    logic signed [PW-1:0]     s2_prod_r;
    logic [IDX_W-1:0]         s2_idx_r;
    logic signed [PW-1:0]     shifted_s;
    logic [DATA_W-1:0]        res_s;
    logic                     sat_s;

    logic                     out_valid_r;
    logic [DATA_W-1:0]        out_data_r;
    logic [IDX_W-1:0]         out_idx_r;
    logic                     frame_done_r;
    logic                     out_sat_r;

    // Global advance: the output slot is empty or being consumed
    always_comb begin
        adv_s    = !out_valid_r || out_ready;
        accept_s = in_valid && adv_s;
        busy_s   = s1_valid_r || s2_valid_r || out_valid_r;
    end

    // Feature index of the next accepted sample, wrapping at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            if (idx_r == LAST_IDX) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    cmvn_param_tbl #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .NUM_FEAT (NUM_FEAT),
        .IDX_W    (IDX_W)
    ) u_tbl (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy_s),
        .in_valid  (in_valid),
        .cfg_err   (cfg_err),
        .rd_en     (adv_s),
        .rd_addr   (idx_r),
        .rd_mean   (tbl_mean_s),
        .rd_istd   (tbl_istd_s)
    );

    // S1 register: sample and index travel alongside the table read
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_W{1'b0}};
            s1_idx_r   <= {IDX_W{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            s1_data_r  <= in_data;
            s1_idx_r   <= idx_r;
        end
    end

    // Centre the sample and scale it, both at full precision
    always_comb begin
        diff_s = $signed({s1_data_r[DATA_W-1], s1_data_r})
               - $signed({tbl_mean_s[DATA_W-1], tbl_mean_s});
        prod_s = PW'(diff_s) * PW'($signed(tbl_istd_s));
    end

    // S2 register: full-width product
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_prod_r  <= {PW{1'b0}};
            s2_idx_r   <= {IDX_W{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_prod_r  <= prod_s;
            s2_idx_r   <= s1_idx_r;
        end
    end

`ifdef CMVN_SAT_EN
    logic [DATA_W+1:0] hi_s;

    // Floor-shift back to the operand format and clamp when out of range
    always_comb begin
        shifted_s = s2_prod_r >>> FRAC_W;
        hi_s      = shifted_s[PW-1:DATA_W-1];
        res_s     = shifted_s[DATA_W-1:0];
        sat_s     = 1'b0;
        if ((|hi_s) && !(&hi_s)) begin
            sat_s = 1'b1;
            if (shifted_s[PW-1]) begin
                res_s = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                res_s = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            sat_s = 1'b0;
        end
    end
`else
    logic unused_hi_s;

    // Floor-shift back to the operand format; upper bits simply drop off
    always_comb begin
        shifted_s   = s2_prod_r >>> FRAC_W;
        res_s       = shifted_s[DATA_W-1:0];
        sat_s       = 1'b0;
        unused_hi_s = ^shifted_s[PW-1:DATA_W];
    end
`endif

    // S3 output register: holds steady while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            out_idx_r    <= {IDX_W{1'b0}};
            frame_done_r <= 1'b0;
            out_sat_r    <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_data_r   <= res_s;
                out_idx_r    <= s2_idx_r;
                frame_done_r <= (s2_idx_r == LAST_IDX);
                out_sat_r    <= sat_s;
            end
        end
    end

    assign in_ready   = adv_s;
    assign busy       = busy_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_idx    = out_idx_r;
    assign frame_done = frame_done_r;
`ifdef CMVN_SAT_EN
    assign out_sat    = out_sat_r;
`else
    logic unused_sat_s;
    assign unused_sat_s = out_sat_r ^ sat_s;
`endif

endmodule

// File: tb/tb_cmvn_stream.sv
// Self-checking bench for cmvn_stream. Expected results come from a plain
// integer model of (x - mean) * istd >> FRAC_W over bench-side table copies.
module tb_cmvn_stream;
    import kws_cmvn_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int FW = DEF_FRAC_W;
    localparam int NF = DEF_NUM_FEAT;
    localparam int IW = $clog2(NF);

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          fd;
        logic          sat;
        int            cyc;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, frame_done;
    logic          cfg_we, cfg_sel, cfg_err, busy, out_sat_w;
    logic [DW-1:0] in_data, out_data, cfg_wdata;
    logic [IW-1:0] out_idx, cfg_addr;

    logic [DW-1:0] mean_m [NF];
    logic [DW-1:0] istd_m [NF];
    rec_t          exp_q[$];
    rec_t          obs_q[$];
    int            acc_cnt, cyc, total, bad;

    always #5 clk = ~clk;

    cmvn_stream #(.DATA_W(DW), .FRAC_W(FW), .NUM_FEAT(NF), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .frame_done(frame_done),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .busy(busy)
`ifdef CMVN_SAT_EN
        , .out_sat(out_sat_w)
`endif
    );
`ifndef CMVN_SAT_EN
    assign out_sat_w = 1'b0;
`endif

    function automatic rec_t model(input logic [DW-1:0] x, input int k);
        longint d, p, r, max_v, min_v;
        rec_t   e;
        max_v = (longint'(1) <<< (DW-1)) - 1;
        min_v = -(longint'(1) <<< (DW-1));
        d = longint'($signed(x)) - longint'($signed(mean_m[k]));
        p = d * longint'($signed(istd_m[k]));
        r = p >>> FW;
        e.data = r[DW-1:0];
        e.sat  = 1'b0;
`ifdef CMVN_SAT_EN
        if (r > max_v) begin e.data = max_v[DW-1:0]; e.sat = 1'b1; end
        if (r < min_v) begin e.data = min_v[DW-1:0]; e.sat = 1'b1; end
`else
        if (r > max_v || r < min_v) e.sat = 1'b0;
`endif
        e.idx = IW'(k);
        e.fd  = (k == NF-1);
        e.cyc = 0;
        return e;
    endfunction

    // One clock of stimulus; logs accepted inputs (with model result) and handshaken outputs
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy);
        rec_t o;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = rdy;
        #1;
        cyc++;
        if (in_valid && in_ready) begin
            o = model(d, acc_cnt % NF);
            o.cyc = cyc;
            exp_q.push_back(o);
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            o.data = out_data; o.idx = out_idx; o.fd = frame_done;
            o.sat = out_sat_w; o.cyc = cyc;
            obs_q.push_back(o);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NF; i++) begin
            mean_m[i] = '0;
            istd_m[i] = ISTD_IDENTITY;
        end
        acc_cnt = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Table write; ok says whether the bench expects it to be applied
    task automatic cfg_write(input logic sel, input logic [IW-1:0] a,
                             input logic [DW-1:0] w, input logic ok, output logic err);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_wdata = w;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        err = cfg_err;
        if (ok) begin
            if (sel == CFG_SEL_ISTD) istd_m[a] = w;
            else mean_m[a] = w;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== '0)    begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_idx !== '0)     begin bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_sat_w !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b want=0", out_sat_w); end
    endtask

    task automatic test_identity();
        do_reset();
        cycle(1'b1, 32'h0100_0000, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL ident_count got=%0d want=1", obs_q.size());
        end else begin
            total++; if (obs_q[0].data !== 32'h0100_0000) begin bad++; $display("FAIL ident_data got=%h want=01000000", obs_q[0].data); end
            total++; if (obs_q[0].idx !== '0) begin bad++; $display("FAIL ident_idx got=%0d want=0", obs_q[0].idx); end
            total++; if (obs_q[0].cyc - exp_q[0].cyc != 3) begin bad++; $display("FAIL ident_latency got=%0d want=3", obs_q[0].cyc - exp_q[0].cyc); end
        end
    endtask

    task automatic test_loaded();
        logic err;
        do_reset();
        for (int a = 0; a < 2; a++) begin
            cfg_write(CFG_SEL_MEAN, IW'(a), 32'd241192656, 1'b1, err);
            cfg_write(CFG_SEL_ISTD, IW'(a), 32'd2730620, 1'b1, err);
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL load_cfg_err got=%b want=0", err); end
        cycle(1'b1, 32'd257969872, 1'b1);
        cycle(1'b1, 32'd241192656, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL load_count got=%0d want=2", obs_q.size());
        end else begin
            total++; if (obs_q[0].data !== 32'd2730620) begin bad++; $display("FAIL load_data0 got=%0d want=2730620", obs_q[0].data); end
            total++; if (obs_q[1].data !== 32'd0) begin bad++; $display("FAIL load_data1 got=%0d want=0", obs_q[1].data); end
        end
        // random tables and random-valid stream against the model
        for (int a = 0; a < NF; a++) begin
            cfg_write(CFG_SEL_MEAN, IW'(a), $urandom, 1'b1, err);
            cfg_write(CFG_SEL_ISTD, IW'(a), $urandom, 1'b1, err);
        end
        exp_q.delete(); obs_q.delete();
        repeat (50) cycle(1'($urandom_range(0, 1)), $urandom, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].idx !== exp_q[i].idx || obs_q[i].sat !== exp_q[i].sat) begin
                bad++; $display("FAIL rand_out[%0d] got=%h/%0d want=%h/%0d", i, obs_q[i].data, obs_q[i].idx, exp_q[i].data, exp_q[i].idx);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int nfd;
        do_reset();
        repeat (45) cycle(1'b1, $urandom, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        nfd = 0;
        total++; if (obs_q.size() != 45) begin bad++; $display("FAIL wrap_count got=%0d want=45", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].fd) nfd++;
            total++;
            if (obs_q[i].idx !== IW'(i % NF) || obs_q[i].fd !== (i % NF == NF-1) || obs_q[i].data !== exp_q[i].data
                || obs_q[i].cyc - exp_q[i].cyc != 3) begin
                bad++; $display("FAIL wrap_out[%0d] got=%0d/%b/%h want=%0d/%b/%h", i, obs_q[i].idx, obs_q[i].fd,
                                obs_q[i].data, i % NF, (i % NF == NF-1), exp_q[i].data);
            end
        end
        total++; if (nfd != 2) begin bad++; $display("FAIL wrap_frame_done_count got=%0d want=2", nfd); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] held;
        int nb;
        do_reset();
        repeat (10) cycle(1'b1, $urandom, 1'b1);
        nb = exp_q.size();
        held = '0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, $urandom, 1'b0);
            if (k == 0) held = out_data;
            else begin
                total++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    bad++; $display("FAIL bp_hold[%0d] got=%h/%b want=%h/1", k, out_data, out_valid, held);
                end
            end
        end
        total++; if (exp_q.size() != nb) begin bad++; $display("FAIL bp_stall_accepts got=%0d want=0", exp_q.size() - nb); end
        repeat (3) cycle(1'b1, $urandom, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        // empty pipeline, output blocked: three samples fill the stages
        nb = exp_q.size();
        repeat (6) cycle(1'b1, $urandom, 1'b0);
        total++; if (exp_q.size() - nb != 3) begin bad++; $display("FAIL bp_fill_accepts got=%0d want=3", exp_q.size() - nb); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].idx !== exp_q[i].idx) begin
                bad++; $display("FAIL bp_out[%0d] got=%h/%0d want=%h/%0d", i, obs_q[i].data, obs_q[i].idx, exp_q[i].data, exp_q[i].idx);
            end
        end
    endtask

    task automatic test_overflow();
        logic err;
        logic [DW-1:0] want0, want1;
        logic          wsat;
`ifdef CMVN_SAT_EN
        want0 = 32'h7FFF_FFFF; want1 = 32'h8000_0000; wsat = 1'b1;
`else
        want0 = 32'hFFFF_FF00; want1 = 32'h0000_0080; wsat = 1'b0;
`endif
        do_reset();
        cfg_write(CFG_SEL_ISTD, IW'(0), 32'h7FFF_FFFF, 1'b1, err);
        cfg_write(CFG_SEL_ISTD, IW'(1), 32'h7FFF_FFFF, 1'b1, err);
        cycle(1'b1, 32'h7FFF_FFFF, 1'b1);
        cycle(1'b1, 32'h8000_0000, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL ovf_count got=%0d want=2", obs_q.size());
        end else begin
            total++; if (obs_q[0].data !== want0) begin bad++; $display("FAIL ovf_pos got=%h want=%h", obs_q[0].data, want0); end
            total++; if (obs_q[1].data !== want1) begin bad++; $display("FAIL ovf_neg got=%h want=%h", obs_q[1].data, want1); end
            total++; if (obs_q[0].sat !== wsat || obs_q[1].sat !== wsat) begin bad++; $display("FAIL ovf_sat got=%b%b want=%b", obs_q[0].sat, obs_q[1].sat, wsat); end
        end
    endtask

    task automatic test_illegal_cfg();
        logic err;
        do_reset();
        cycle(1'b1, $urandom, 1'b1);
        cycle(1'b1, $urandom, 1'b1);
        cfg_write(CFG_SEL_MEAN, IW'(2), 32'h1234_5678, 1'b0, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL cfg_busy_err got=%b want=1", err); end
        cycle(1'b0, 32'h0, 1'b1);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse got=%b want=0", cfg_err); end
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        cfg_write(CFG_SEL_ISTD, IW'(25), 32'h0000_0001, 1'b0, err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL cfg_addr_err got=%b want=1", err); end
        cfg_write(CFG_SEL_MEAN, IW'(3), 32'h0080_0000, 1'b1, err);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL cfg_legal_err got=%b want=0", err); end
        cycle(1'b1, 32'h0300_0000, 1'b1);
        cycle(1'b1, 32'h0300_0000, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (obs_q.size() != 4) begin
            bad++; $display("FAIL cfg_count got=%0d want=4", obs_q.size());
        end else begin
            total++; if (obs_q[2].data !== 32'h0300_0000) begin bad++; $display("FAIL cfg_unchanged got=%h want=03000000", obs_q[2].data); end
            total++; if (obs_q[3].data !== 32'h0280_0000) begin bad++; $display("FAIL cfg_applied got=%h want=02800000", obs_q[3].data); end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (obs_q[i].data !== exp_q[i].data || obs_q[i].idx !== exp_q[i].idx) begin
                    bad++; $display("FAIL cfg_out[%0d] got=%h want=%h", i, obs_q[i].data, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic err;
        logic [DW-1:0] x;
        do_reset();
        cfg_write(CFG_SEL_MEAN, IW'(0), 32'h0100_0000, 1'b1, err);
        repeat (7) cycle(1'b1, $urandom, 1'b1);
        do_reset();
        x = $urandom;
        cycle(1'b1, x, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (obs_q.size() != 1) begin
            bad++; $display("FAIL mrst_count got=%0d want=1", obs_q.size());
        end else begin
            total++; if (obs_q[0].idx !== '0) begin bad++; $display("FAIL mrst_idx got=%0d want=0", obs_q[0].idx); end
            total++; if (obs_q[0].data !== x) begin bad++; $display("FAIL mrst_data got=%h want=%h", obs_q[0].data, x); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        total = 0; bad = 0; cyc = 0; acc_cnt = 0;
        test_reset();
        test_identity();
        test_loaded();
        test_frame_wrap();
        test_back_pressure();
        test_overflow();
        test_illegal_cfg();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmvn_stream.md
# cmvn_stream

Parametrised, streaming cepstral mean/variance normaliser for the KWS front end. It sits between the feature extractor and the first network layer. Each incoming fixed-point feature is normalised as (x − mean[k]) · istd[k], where k is the feature's position within the frame. The per-feature mean and istd tables are run-time loadable. Data moves through a stallable 3-stage pipeline with valid/ready handshakes.

## Interface
- DATA_W, 32: sample, mean and istd width, signed two's complement.
- FRAC_W, 24: fractional bits of every operand and of the result (default format 1.7.24).
- NUM_FEAT, 20: features per frame, i.e. table depth; must be ≥ 2.
- IDX_W, $clog2(NUM_FEAT): width of feature index and table address.

Ports:
- clk, in, 1: sole clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: in_data is valid this cycle.
- in_ready, out, 1: block accepts in_data this cycle.
- in_data, in, DATA_W: raw feature sample, frame order 0..NUM_FEAT−1.
- out_valid, out, 1: out_data, out_idx and frame_done are valid.
- out_ready, in, 1: downstream accepts the output.
- out_data, out, DATA_W: normalised feature.
- out_idx, out, IDX_W: feature index of out_data.
- frame_done, out, 1: asserted with the output for index NUM_FEAT−1.
- cfg_we, in, 1: table write strobe.
- cfg_sel, in, 1: write target; 0 = mean, 1 = istd.
- cfg_addr, in, IDX_W: table entry to write.
- cfg_wdata, in, DATA_W: value to write.
- cfg_err, out, 1: one-cycle pulse when a write is rejected.
- busy, out, 1: any pipeline stage holds valid data.

## Operation
- Input index counter: starts at 0, +1 per accepted input, wraps NUM_FEAT−1 → 0. It travels down the pipeline with the sample.
- S1: reads mean[idx] and istd[idx]; computes d = in_data − mean as DATA_W+1 bits, signed.
- S2: p = d · istd, 2·DATA_W+1 bits, signed.
- S3: r = p >>> FRAC_W (arithmetic shift, i.e. floor). out_data = r[DATA_W−1:0]; overflow behaviour is set by CMVN_SAT_EN.
- Stall rule: in_ready = !out_valid || out_ready. The whole pipeline advances only when in_ready = 1; bubbles propagate as invalid stages.
- Table writes:
  - Applied at the clock edge only when busy = 0 and in_valid = 0.
  - Otherwise the write is dropped and cfg_err pulses on the next cycle.
  - cfg_addr ≥ NUM_FEAT is also dropped, with cfg_err.
- rst:
  - Clears all stage valids; index counter = 0.
  - Tables return to identity: mean = 0, istd = 1 << FRAC_W.
  - Any frame in progress is discarded.
- Reset outputs: in_ready = 1, out_valid = 0, out_data = 0, out_idx = 0, frame_done = 0, cfg_err = 0, busy = 0.

## Timing
- Latency: input accepted at edge N → out_valid at edge N+3, provided out_ready is held high.
- Throughput: one sample per cycle with no backpressure.
- While out_valid = 1 and out_ready = 0, out_data, out_idx and frame_done hold stable.
- Table reads are registered in S1. A write takes effect for the first input accepted after the write edge.

## Configuration
- CMVN_SAT_EN defined:
  - r above 2^(DATA_W−1)−1 clamps to that maximum; r below −2^(DATA_W−1) clamps to that minimum.
  - Adds output port out_sat (1 bit, reset 0), asserted with any clamped output.
- CMVN_SAT_EN undefined: plain truncation, r[DATA_W−1:0]; no out_sat port.

## Structure
- Package kws_cmvn_pkg holds:
  - default DATA_W, FRAC_W, NUM_FEAT;
  - the CFG_SEL_MEAN / CFG_SEL_ISTD constants;
  - the identity-istd constant.
- Sub-module cmvn_param_tbl holds both register-array tables, the synchronous reset to identity, and write-port gating with cfg_err generation. It exposes one registered read port.

## Test plan
- Identity after reset: in_data 0x0100_0000 → out_data 0x0100_0000 exactly 3 cycles later; out_idx 0.
- Loaded entry:
  - Stimulus: mean[0] = 241192656, istd[0] = 2730620; in_data 257969872.
  - Required: out_data 2730620.
  - Also: in_data 241192656 → out_data 0.
- Frame wrap: 45 back-to-back inputs → out_idx sequence 0..19, 0..19, 0..4; frame_done only on the two idx-19 outputs.
- Backpressure: out_ready low 5 cycles mid-stream → out_data held; exactly 3 further inputs accepted then in_ready 0; no loss or duplication.
- Overflow:
  - Stimulus: mean 0, istd 0x7FFF_FFFF, in_data 0x7FFF_FFFF.
  - With CMVN_SAT_EN: out_data 0x7FFF_FFFF, out_sat 1.
  - Without CMVN_SAT_EN: out_data 0xFFFF_FF00.
- Illegal cfg / mid-frame reset:
  - cfg_we while busy → cfg_err pulse, table unchanged.
  - rst after 7 inputs → next output has out_idx 0 and identity result.
